// File: rtl/eth_mmio_arbiter.sv
// eth_mmio_arbiter
//   Shares the single MMIO port of the ethernet controller among num_req_p
//   requesters using round-robin arbitration, with one transaction in flight
//   at a time. Every command toward the controller is registered. Each write
//   ack or read response goes back to the requester that issued it. A
//   watchdog turns a read that never returns data into an error response.
//
// Ports
//   clk_i, reset_n_i            clock, async active-low reset
//   req_v_i / req_ready_o       per-requester valid / one-hot accept (IDLE only)
//   req_addr_i/we/size/data     flattened per-requester command fields
//   resp_v_o                    one-hot, one-cycle response strobe
//   resp_data_o, resp_err_o     read data (0 for writes/errors), timeout flag
//   addr_o .. write_data_o      command toward controller
//   read_data_i, read_data_v_i  read return from controller
module eth_mmio_arbiter #(
    parameter int num_req_p    = 2,
    parameter int addr_width_p = 16,
    parameter int data_width_p = 64,
    parameter int timeout_p    = 64
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    output logic [num_req_p-1:0]                 req_ready_o,
    input  logic [num_req_p*addr_width_p-1:0]    req_addr_i,
    input  logic [num_req_p-1:0]                 req_we_i,
    input  logic [num_req_p*2-1:0]               req_size_i,
    input  logic [num_req_p*data_width_p-1:0]    req_data_i,
    output logic [num_req_p-1:0]                 resp_v_o,
    output logic [data_width_p-1:0]              resp_data_o,
    output logic                                 resp_err_o,
    output logic [addr_width_p-1:0]              addr_o,
    output logic                                 write_en_o,
    output logic                                 read_en_o,
    output logic [1:0]                           op_size_o,
    output logic [data_width_p-1:0]              write_data_o,
    input  logic [data_width_p-1:0]              read_data_i,
    input  logic                                 read_data_v_i
);

    localparam int gw = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int ww = $clog2(timeout_p + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_e;

    typedef struct packed {
        logic [addr_width_p-1:0] addr;
        logic                    we;
        logic [1:0]              size;
        logic [data_width_p-1:0] data;
    } cmd_t;

    state_e                  state, state_n;
    cmd_t                    cmd;
    logic [gw-1:0]           owner, last_grant, winner, idx_g;
    logic                    any_req;
    int                      idx;
    logic [ww-1:0]           wdog;
    logic                    wdog_hit;
    logic [data_width_p-1:0] resp_data;
    logic                    resp_err;

    // Round-robin pick: first requester above last_grant, wrapping.
    always_comb begin
        winner  = last_grant;
        any_req = 1'b0;
        idx     = 0;
        idx_g   = '0;
        for (int k = 1; k <= num_req_p; k++) begin
            idx   = (int'(last_grant) + k) % num_req_p;
            idx_g = gw'(idx);
            if (!any_req && req_v_i[idx_g]) begin
                any_req = 1'b1;
                winner  = idx_g;
            end
        end
    end

    assign wdog_hit = (wdog == ww'(timeout_p - 1));

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_req) state_n = ISSUE;
            ISSUE:   state_n = cmd.we ? RESP : WAIT_RD;
            WAIT_RD: if (read_data_v_i || wdog_hit) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready_o = '0;
        resp_v_o    = '0;
        // No handshake may complete while reset is held.
        if (state == IDLE && any_req && reset_n_i) req_ready_o[winner] = 1'b1;
        if (state == RESP) resp_v_o[owner] = 1'b1;
        write_en_o   = (state == ISSUE) &&  cmd.we;
        read_en_o    = (state == ISSUE) && !cmd.we;
        addr_o       = cmd.addr;
        op_size_o    = cmd.size;
        write_data_o = cmd.data;
        resp_data_o  = resp_data;
        resp_err_o   = resp_err;
    end

    // Datapath: command latch, grant pointer, watchdog, response regs.
    // Response regs default to 0 so they are only non-zero during RESP.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd        <= '0;
            owner      <= '0;
            last_grant <= gw'(num_req_p - 1);
            wdog       <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_data <= '0;
            resp_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cmd <= '{addr: req_addr_i[winner*addr_width_p +: addr_width_p],
                                 we:   req_we_i[winner],
                                 size: req_size_i[winner*2 +: 2],
                                 data: req_data_i[winner*data_width_p +: data_width_p]};
                        owner      <= winner;
                        last_grant <= winner;
                    end
                end
                ISSUE: wdog <= '0;
                WAIT_RD: begin
                    if (wdog != '1) wdog <= wdog + ww'(1);
                    // Valid data beats a simultaneous timeout.
                    if (read_data_v_i) resp_data <= read_data_i;
                    else if (wdog_hit) resp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/eth_mmio_arbiter.md
# eth_mmio_arbiter

Round-robin arbiter that shares the single MMIO port of the ethernet controller (addr/write_en/read_en/op_size/write_data, sync read data with valid) between `num_req_p` requesters, e.g. the host bus bridge and a DMA engine. It keeps at most one transaction outstanding, registers every command toward the controller, and routes each write acknowledge or read response back to the requester that issued it. A watchdog counter converts a missing read-data valid into an error response so a requester can never hang.

## Interface
- `num_req_p`, 2, number of requesters (2..8)
- `addr_width_p`, 16, MMIO address width
- `data_width_p`, 64, data width; matches controller `axis_width_p`
- `timeout_p`, 64, cycles to wait for read data before an error response (≥2)

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i` in 1: sole clock, same domain as the controller MMIO port
- `reset_n_i` in 1: asynchronous, active-low reset
- `req_v_i` in `num_req_p`: per-requester command valid
- `req_ready_o` out `num_req_p`: one-hot accept
- `req_addr_i` in `num_req_p*addr_width_p`: flattened; requester i at slice i
- `req_we_i` in `num_req_p`: 1 = write, 0 = read
- `req_size_i` in `num_req_p*2`: op size
- `req_data_i` in `num_req_p*data_width_p`: write data
- `resp_v_o` out `num_req_p`: one-hot response valid, one cycle
- `resp_data_o` out `data_width_p`: read data; 0 for writes and errors
- `resp_err_o` out 1: response is a read timeout
- `addr_o` out `addr_width_p`; `write_en_o` out 1; `read_en_o` out 1; `op_size_o` out 2; `write_data_o` out `data_width_p`: to controller
- `read_data_i` in `data_width_p`; `read_data_v_i` in 1: from controller

## Operation
- States: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: if any `req_v_i`, the winner is the first set bit searching from `(last_grant+1) mod num_req_p` upward with wrap. `req_ready_o[winner]=1` combinationally, same cycle. The handshake completes in that cycle. The fields are latched, `owner<=winner`, `last_grant<=winner`, and the state goes to ISSUE.
- Requesters hold `req_v_i` and their fields stable until they see ready. Ready is 0 in every state except IDLE.
- ISSUE (one cycle): `addr_o`/`op_size_o`/`write_data_o` drive the latched values, and exactly one of `write_en_o`/`read_en_o` is 1.
  - Write: go to RESP with data 0 and err 0.
  - Read: clear the watchdog and go to WAIT_RD.
- WAIT_RD: `addr_o`/`op_size_o` hold; the enables are 0. The watchdog increments each cycle.
  - `read_data_v_i=1`: capture `read_data_i` and go to RESP with err 0.
  - Else, if the watchdog equals `timeout_p-1`: go to RESP with data 0 and err 1.
  - If both happen in the same cycle, valid data wins.
- RESP (one cycle): `resp_v_o[owner]=1`, with `resp_data_o` and `resp_err_o` registered. Then go to IDLE.
- `read_data_v_i` is ignored outside WAIT_RD. This covers stray or late data after a timeout.
- Watchdog width is `$clog2(timeout_p+1)` and it saturates; it never wraps.
- `last_grant` resets to `num_req_p-1`, so requester 0 has first priority.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): state IDLE, all `*_o` are 0, watchdog 0. `resp_data_o` is 0, which also covers the outputs while idle.
- Reset mid-transaction aborts with no response. The enables drop to 0 asynchronously.
- Write, accepted at cycle T: `write_en_o` at T+1, `resp_v_o` at T+2. The next accept is possible at T+3.
- Read, accepted at T: `read_en_o` at T+1. With controller data valid at T+2, `resp_v_o` is at T+3. This is a 3-cycle minimum latency; each extra controller delay cycle adds one.
- Timeout read: `resp_v_o` with err at T+1+`timeout_p`+1.
- Fairness: every continuously requesting requester is granted within `num_req_p` grants.

## Test plan
- Single write from requester 0: addr 0x0010, data 0xDEADBEEF, size 3 -> `write_en_o` for one cycle with those values at T+1; `resp_v_o=2'b01`, err 0 at T+2.
- Read from requester 1, controller returns 0x1234 one cycle after `read_en_o` -> `resp_v_o=2'b10`, `resp_data_o=0x1234` at T+3.
- Both requesters assert reads continuously after reset -> grant order 0,1,0,1. `req_ready_o` is never 2'b11.
- Controller never asserts `read_data_v_i`, `timeout_p=8` -> `resp_err_o=1` and data 0 at T+10. A late `read_data_v_i` afterwards produces no `resp_v_o`.
- `read_data_v_i` on exactly the timeout cycle -> data response with err 0.
- Assert `reset_n_i` low during WAIT_RD -> all outputs are 0 immediately. After release there is no response, and the first grant goes to requester 0.
